pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program-counter register and fetch sequencer that sits directly upstream of the PC+4 adder. It drives the current PC to the adder and to instruction memory, and takes PC4 back from the adder. It selects the next PC from PC4, a branch target or a jump target, and holds PC through stalls and memory wait states. A fetch handshake with instruction memory makes the PC update strictly sequential.

Parameters:
WIDTH, 32, PC/address width (matches the PC+4 adder).
RESET_PC, 0, PC value loaded on reset.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
pc  output  WIDTH  current PC; feeds the PC+4 adder input and imem address
pc4  input  WIDTH  PC+4 returned by the adder (combinational from pc)
stall  input  1  hazard stall; freeze PC, issue no new request
branch_taken  input  1  branch redirect valid (one-cycle pulse)
branch_target  input  WIDTH  branch destination
jump  input  1  jump redirect valid (one-cycle pulse)
jump_target  input  WIDTH  jump destination
imem_req  output  1  fetch request for address pc
imem_ready  input  1  imem accepts/completes the fetch this cycle
fetch_valid  output  1  one-cycle pulse: instruction for fetch_pc has been accepted
fetch_pc  output  WIDTH  PC of the accepted fetch

Behaviour:
- Reset (reset_n=0, async): pc=RESET_PC, state=IDLE, imem_req=0, fetch_valid=0, fetch_pc=0, redirect pending flag cleared, pend_target=0.
- States: IDLE, REQ, STALL.
- IDLE: the cycle after reset release goes to REQ (or STALL if stall=1).
- REQ: imem_req=1.
  - imem_ready=1: fetch_valid=1 next cycle, fetch_pc<=pc, and pc<=next_pc.
  - Then go to STALL if stall=1, else stay in REQ.
  - imem_ready=0: pc held, stay in REQ.
- STALL: imem_req=0, pc held. Return to REQ on the first cycle with stall=0.
- next_pc priority: jump > branch_taken > pending redirect > pc4.
- Redirect arriving while in REQ with imem_ready=0: capture the target into pend_target and set the pending flag. The in-flight request address is never changed mid-transaction. The pending target is applied at the next accepted fetch.
- A later redirect before acceptance overwrites the pending one. jump beats branch in the same cycle.
- Redirect arriving in STALL or IDLE: pc<=target immediately (next edge), and the pending flag is cleared.
- Redirect coincident with imem_ready=1: pc<=target, and the fetch of the old pc still completes (fetch_valid=1).
- Latency: imem_ready high at edge N -> pc and fetch_valid updated at edge N. Back-to-back fetches are possible every cycle when imem_ready is held at 1.
- Arithmetic: pc4 is used unmodified. Wrap-around at 2^WIDTH-4 is the adder's concern; pc follows pc4 = 0.
- stall and imem_ready both 1 in REQ: the fetch completes, then the block enters STALL.
- Reset mid-transaction: the request is dropped immediately, with no fetch_valid.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: adds output align_err (1 bit, reset 0).
  - A branch or jump target with target[1:0]!=0 sets align_err sticky until reset.
  - The target is loaded with bits [1:0] forced to 0.
- Undefined: no align_err port; targets are loaded unmodified.

Decomposition:
- Package pc_fetch_pkg: fetch_state_t enum (IDLE, REQ, STALL) and a localparam for the 2'b00 alignment mask.
- One sub-module: pc_next_mux, a combinational priority select of jump/branch/pending/pc4 (plus alignment masking when enabled).
- FSM and registers stay in pc_fetch_ctrl.

Test Plan:
- Reset, then imem_ready=1 constantly with the adder model pc4=pc+4 -> pc sequence 0,4,8,12,16; fetch_valid every cycle with fetch_pc 0,4,8,12.
- imem_ready low for 3 cycles at pc=8 -> imem_req=1 and pc=8 held, fetch_valid=0; on ready, fetch_pc=8 and pc=12.
- branch_taken pulse with branch_target=0x40 while waiting at pc=8 -> fetch_pc=8 at acceptance, then pc=0x40, then pc 0x44.
- jump (0x100) and branch (0x40) in the same cycle in STALL -> pc=0x100.
- stall=1 for 2 cycles at pc=0x10 -> imem_req=0, pc=0x10 held; after release the fetch of 0x10 completes.
- reset_n pulled low mid-REQ at pc=0x20 -> pc=0 and imem_req=0 asynchronously; with PC_ALIGN_CHECK_EN, a jump to 0x102 -> pc=0x100 and align_err=1.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Optional build macro: PC_ALIGN_CHECK_EN (see pc_next_mux / pc_fetch_ctrl).
package pc_fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2
  } fetch_state_t;

  // Low address bits of a word-aligned instruction address.
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  // True when the two low bits do not describe a word-aligned address.
  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: jump > branch > pending redirect > pc4.
// Also presents the current-cycle redirect target so the controller can
// load it directly or park it as a pending redirect.
// With PC_ALIGN_CHECK_EN defined, redirect targets have bits [1:0] cleared
// and a misaligned-target flag is produced.
module pc_next_mux
  import pc_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  input  logic [WIDTH-1:0] pc4,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_target,
  output logic [WIDTH-1:0] next_pc
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

  logic [WIDTH-1:0] raw_target;

  // Pick the redirect source (jump wins) and resolve the final next PC.
  always_comb begin
    redirect   = jump | branch_taken;
    raw_target = jump ? jump_target : branch_target;
`ifdef PC_ALIGN_CHECK_EN
    redirect_target = {raw_target[WIDTH-1:2], ALIGN_MASK};
    misaligned      = (jump && is_misaligned(jump_target[1:0])) ||
                      (branch_taken && is_misaligned(branch_target[1:0]));
`else
    redirect_target = raw_target;
`endif
    if (redirect) begin
      next_pc = redirect_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end else begin
      next_pc = pc4;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer feeding the PC+4 adder and
// instruction memory. PC only advances when a fetch is accepted, so the
// request address never changes mid-transaction; redirects that arrive
// while a request is waiting are parked and applied at acceptance.
// Optional build macro: PC_ALIGN_CHECK_EN adds the sticky align_err output.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc4,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_pc
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             align_err
`endif
);

  fetch_state_t     state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             pend_valid_reg, pend_valid_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  logic             fetch_valid_reg, fetch_valid_next;
  logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;

  logic             redirect;
  logic [WIDTH-1:0] redirect_target;
  logic [WIDTH-1:0] mux_next_pc;

`ifdef PC_ALIGN_CHECK_EN
  logic             misaligned;
  logic             align_err_reg, align_err_next;
`endif

  pc_next_mux #(
    .WIDTH(WIDTH)
  ) u_next_mux (
    .jump            (jump),
    .jump_target     (jump_target),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .pend_valid      (pend_valid_reg),
    .pend_target     (pend_target_reg),
    .pc4             (pc4),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .next_pc         (mux_next_pc)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned      (misaligned)
`endif
  );

  // State and datapath registers; reset drops any in-flight request at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
      fetch_valid_reg <= 1'b0;
      fetch_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      fetch_valid_reg <= fetch_valid_next;
      fetch_pc_reg    <= fetch_pc_next;
    end
  end

  // Next-state, PC update and request generation.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    fetch_valid_next = 1'b0;
    fetch_pc_next    = fetch_pc_reg;
    imem_req         = 1'b0;

    case (state_reg)
      IDLE: begin
        // No request outstanding: a redirect can be taken immediately.
        if (redirect) begin
          pc_next         = redirect_target;
          pend_valid_next = 1'b0;
        end
        state_next = stall ? STALL : REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          fetch_valid_next = 1'b1;
          fetch_pc_next    = pc_reg;
          pc_next          = mux_next_pc;
          pend_valid_next  = 1'b0;
          state_next       = stall ? STALL : REQ;
        end else if (redirect) begin
          // Keep the waiting address stable; remember where to go next.
          pend_valid_next  = 1'b1;
          pend_target_next = redirect_target;
        end
      end

      STALL: begin
        if (redirect) begin
          pc_next         = redirect_target;
          pend_valid_next = 1'b0;
        end
        if (!stall) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky flag for any misaligned redirect target seen since reset.
  always_comb begin
    align_err_next = align_err_reg | misaligned;
  end

  // Alignment error register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      align_err_reg <= 1'b0;
    end else begin
      align_err_reg <= align_err_next;
    end
  end

  assign align_err = align_err_reg;
`endif

  assign pc          = pc_reg;
  assign fetch_valid = fetch_valid_reg;
  assign fetch_pc    = fetch_pc_reg;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed sequence with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_pc_fetch_ctrl;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] pc;
  logic [W-1:0] pc4;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_target = '0;
  logic         jump = 1'b0;
  logic [W-1:0] jump_target = '0;
  logic         imem_req;
  logic         imem_ready = 1'b0;
  logic         fetch_valid;
  logic [W-1:0] fetch_pc;
`ifdef PC_ALIGN_CHECK_EN
  logic         align_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Adder stand-in: combinational PC+4.
  assign pc4 = pc + 32'd4;

  always #5 clock = ~clock;

  pc_fetch_ctrl #(
    .WIDTH   (W),
    .RESET_PC(32'h0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pc            (pc),
    .pc4           (pc4),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_ready    (imem_ready),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .align_err     (align_err)
`endif
  );

  // Behavioural model. phase: 0 = just out of reset, 1 = requesting,
  // 2 = held by stall. Pending redirect is a simple valid/target pair.
  int           m_phase, n_phase;
  logic [W-1:0] m_pc, n_pc, m_fpc, n_fpc, m_ptgt, n_ptgt;
  bit           m_fv, n_fv, m_pend, n_pend, m_aerr, n_aerr;

  task automatic model_reset();
    m_phase = 0; m_pc = 32'h0; m_fpc = 32'h0; m_ptgt = 32'h0;
    m_fv = 1'b0; m_pend = 1'b0; m_aerr = 1'b0;
  endtask

  task automatic model_step();
    logic         redir;
    logic [W-1:0] tgt;
    n_phase = m_phase; n_pc = m_pc; n_fpc = m_fpc; n_ptgt = m_ptgt;
    n_fv = 1'b0; n_pend = m_pend; n_aerr = m_aerr;
    redir = jump | branch_taken;
    tgt   = jump ? jump_target : branch_target;
`ifdef PC_ALIGN_CHECK_EN
    tgt = tgt & ~32'h3;
    if ((jump && jump_target[1:0] != 2'b00) ||
        (branch_taken && branch_target[1:0] != 2'b00)) n_aerr = 1'b1;
`endif
    if (m_phase == 0) begin
      if (redir) begin n_pc = tgt; n_pend = 1'b0; end
      n_phase = stall ? 2 : 1;
    end else if (m_phase == 1) begin
      if (imem_ready) begin
        n_fv  = 1'b1;
        n_fpc = m_pc;
        n_pc  = redir ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
        n_pend = 1'b0;
        n_phase = stall ? 2 : 1;
      end else if (redir) begin
        n_pend = 1'b1;
        n_ptgt = tgt;
      end
    end else begin
      if (redir) begin n_pc = tgt; n_pend = 1'b0; end
      if (!stall) n_phase = 1;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_imem_req", 32'(imem_req), 32'(m_phase == 1));
      check("model_fetch_valid", 32'(fetch_valid), 32'(m_fv));
      check("model_fetch_pc", fetch_pc, m_fpc);
`ifdef PC_ALIGN_CHECK_EN
      check("model_align_err", 32'(align_err), 32'(m_aerr));
`endif
    end
  end

  // Apply one cycle of inputs (called just after a rising edge).
  task automatic step(input bit s, input bit r, input bit b, input logic [W-1:0] bt,
                      input bit j, input logic [W-1:0] jt);
    stall = s; imem_ready = r; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    model_step();
    @(posedge clock);
    #1;
    m_phase = n_phase; m_pc = n_pc; m_fpc = n_fpc; m_ptgt = n_ptgt;
    m_fv = n_fv; m_pend = n_pend; m_aerr = n_aerr;
    $display("cyc t=%0t stall=%0b rdy=%0b br=%0b jmp=%0b -> pc=%h req=%0b fv=%0b fpc=%h",
             $time, s, r, b, j, pc, imem_req, fetch_valid, fetch_pc);
  endtask

  // Asynchronous reset asserted between edges, held across one edge.
  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_en  = 1'b1;
    reset_n = 1'b1;

    // Reset state.
    check("rst_pc", pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_fv", 32'(fetch_valid), 32'h0);
    check("rst_fpc", fetch_pc, 32'h0);

    // Sequential fetch with ready held high.
    step(0, 1, 0, 0, 0, 0);
    check("idle_to_req", 32'(imem_req), 32'h1);
    check("first_pc", pc, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    check("seq_pc4", pc, 32'h4);
    check("seq_fv", 32'(fetch_valid), 32'h1);
    check("seq_fpc0", fetch_pc, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    check("seq_pc8", pc, 32'h8);
    check("seq_fpc4", fetch_pc, 32'h4);

    // Wait states at pc=8, with a branch arriving mid-wait.
    step(0, 0, 0, 0, 0, 0);
    check("wait_pc", pc, 32'h8);
    check("wait_fv", 32'(fetch_valid), 32'h0);
    step(0, 0, 1, 32'h40, 0, 0);
    check("wait_br_pc_held", pc, 32'h8);
    check("wait_req", 32'(imem_req), 32'h1);
    step(0, 0, 0, 0, 0, 0);
    check("wait3_pc", pc, 32'h8);
    step(0, 1, 0, 0, 0, 0);
    check("accept_fpc8", fetch_pc, 32'h8);
    check("accept_pend_pc", pc, 32'h40);
    step(0, 1, 0, 0, 0, 0);
    check("after_br_pc", pc, 32'h44);

    // Stall with ready: fetch completes, then stalled.
    step(1, 1, 0, 0, 0, 0);
    check("stall_accept_fpc", fetch_pc, 32'h44);
    check("stall_accept_pc", pc, 32'h48);
    step(1, 1, 0, 0, 0, 0);
    check("stall_req", 32'(imem_req), 32'h0);
    check("stall_pc", pc, 32'h48);
    check("stall_fv", 32'(fetch_valid), 32'h0);
    // Jump beats branch while stalled.
    step(1, 0, 1, 32'h40, 1, 32'h100);
    check("jmp_over_br", pc, 32'h100);
    step(0, 1, 0, 0, 0, 0);
    check("unstall_req", 32'(imem_req), 32'h1);
    step(0, 1, 0, 0, 0, 0);
    check("unstall_fpc", fetch_pc, 32'h100);
    check("unstall_pc", pc, 32'h104);

    // Reset in the middle of a waiting request.
    step(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_req", 32'(imem_req), 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Misaligned jump straight out of reset.
    step(0, 0, 0, 0, 1, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc", pc, 32'h100);
    check("align_err", 32'(align_err), 32'h1);
`else
    check("unaligned_pc", pc, 32'h102);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        logic [W-1:0] bt, jt;
        bt = $urandom;
        jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
        if ($urandom_range(0, 3) != 0) begin
          bt[1:0] = 2'b00;
          jt[1:0] = 2'b00;
        end
        step($urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 9) == 0, bt,
             $urandom_range(0, 11) == 0, jt);
      end
    end

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
